// File: rtl/high_score_ctrl.sv
// high_score_ctrl: Snake game-session controller tracking score, elapsed ticks, the high score and the BCD display value.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            pulse, begins a new session from IDLE or DONE
//   eat              pulse, increments the saturating score while playing
//   game_over        pulse, ends the session, updates high score, starts BCD conversion
//   score            current session score
//   high_score       best final score since reset
//   time_ticks       TICK_DIV-cycle ticks elapsed while playing
//   bcd_out          BCD of the last final score, digit 0 in [3:0]
//   bcd_valid        bcd_out holds a completed conversion
//   new_record       last session beat the stored high score
//   busy             session playing or converting
module high_score_ctrl #(
    parameter int TICK_DIV = 15,
    parameter int SCORE_W  = 16,
    parameter int DIGITS   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                eat,
    input  logic                game_over,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  high_score,
    output logic [31:0]         time_ticks,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid,
    output logic                new_record,
    output logic                busy
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + SCORE_W;
    localparam int DW = $clog2(TICK_DIV);
    localparam int IW = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {IDLE, PLAY, CONVERT, DONE} state_t;
    state_t state, state_nx;

    logic [DW-1:0]      div;
    logic [IW-1:0]      iter;
    logic [SW-1:0]      sh, adj, dd_next;
    logic [SCORE_W-1:0] score_inc;
    logic               tick, last_iter;

    // Same-cycle eat is folded into the final score at game_over.
    assign score_inc = (eat && score != '1) ? score + SCORE_W'(1) : score;
    assign tick      = div == DW'(TICK_DIV - 1);
    assign last_iter = iter == IW'(SCORE_W - 1);
    assign busy      = state == PLAY || state == CONVERT;

    // One double-dabble step: add 3 to every digit >= 5, then shift {bcd,bin} left.
    always_comb begin
        adj = sh;
        for (int i = 0; i < DIGITS; i++)
            if (adj[SCORE_W+4*i +: 4] >= 4'd5)
                adj[SCORE_W+4*i +: 4] = adj[SCORE_W+4*i +: 4] + 4'd3;
        dd_next = adj << 1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? PLAY : state;
            PLAY:       state_nx = game_over ? CONVERT : PLAY;
            CONVERT:    state_nx = last_iter ? DONE : CONVERT;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            time_ticks <= '0;
            bcd_out    <= '0;
            bcd_valid  <= 1'b0;
            new_record <= 1'b0;
            div        <= '0;
            iter       <= '0;
            sh         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score      <= '0;
                        time_ticks <= '0;
                        div        <= '0;
                        new_record <= 1'b0;
                        bcd_valid  <= 1'b0;
                    end
                end
                PLAY: begin
                    div   <= tick ? '0 : div + DW'(1);
                    score <= score_inc;
                    if (tick) time_ticks <= time_ticks + 32'd1;
                    if (game_over) begin
                        // Equal to the stored best is not a record.
                        if (score_inc > high_score) begin
                            high_score <= score_inc;
                            new_record <= 1'b1;
                        end
                        sh   <= {{BW{1'b0}}, score_inc};
                        iter <= '0;
                    end
                end
                CONVERT: begin
                    sh   <= dd_next;
                    iter <= iter + IW'(1);
                    if (last_iter) begin
                        bcd_out   <= dd_next[SW-1 -: BW];
                        bcd_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_high_score_ctrl.sv
// tb_high_score_ctrl: scoreboard bench for high_score_ctrl with a decimal reference model.
module tb_high_score_ctrl;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, eat = 1'b0, game_over = 1'b0;
    logic [15:0] score, high_score;
    logic [31:0] time_ticks;
    logic [19:0] bcd_out;
    logic        bcd_valid, new_record, busy;

    high_score_ctrl #(.TICK_DIV(15), .SCORE_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .game_over(game_over),
        .score(score), .high_score(high_score), .time_ticks(time_ticks),
        .bcd_out(bcd_out), .bcd_valid(bcd_valid), .new_record(new_record), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic [15:0] high;
        logic        rec;
        logic [19:0] bcd;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0, n_fail = 0;
    int m_score = 0, m_high = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_score = 0;
    endtask

    task automatic do_eat();
        eat = 1'b1;
        step();
        eat = 1'b0;
        if (m_score < 65535) m_score++;
    endtask

    // Ends the session (optionally with eat and/or start in the same cycle), then waits for the BCD result.
    task automatic go_over(input bit with_eat, input bit with_start, input bit poke);
        exp_t e;
        int n;
        if (with_eat && m_score < 65535) m_score++;
        e.score = 16'(m_score);
        e.rec   = m_score > m_high;
        if (e.rec) m_high = m_score;
        e.high  = 16'(m_high);
        e.bcd   = to_bcd(m_score);
        sb.push_back(e);
        eat = with_eat;
        start = with_start;
        game_over = 1'b1;
        step();
        {eat, start, game_over} = 3'b000;
        check("busy_convert", busy, 1'b1);
        n = 0;
        while (!bcd_valid && n < 40) begin
            start = poke && n == 4;
            step();
            n++;
        end
        start = 1'b0;
        check("bcd_latency", n, 16);
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
            e = sb.pop_front();
            check("score", score, e.score);
            check("high_score", high_score, e.high);
            check("new_record", new_record, e.rec);
            check("bcd_out", bcd_out, e.bcd);
            check("busy_done", busy, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_score"}, score, 0);
        check({tag, "_high"}, high_score, 0);
        check({tag, "_ticks"}, time_ticks, 0);
        check({tag, "_bcd"}, bcd_out, 0);
        check({tag, "_valid"}, bcd_valid, 0);
        check({tag, "_rec"}, new_record, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step();

        // Session 1: three eats, first record.
        do_start();
        check("busy_play", busy, 1'b1);
        repeat (3) begin
            do_eat();
            step();
        end
        check("score_3", score, 3);
        go_over(1'b0, 1'b0, 1'b0);

        // Session 2: score 2 with coincident eat; session 3 ties the record.
        do_start();
        check("valid_cleared", bcd_valid, 1'b0);
        check("score_cleared", score, 0);
        do_eat();
        go_over(1'b1, 1'b0, 1'b0);
        do_start();
        repeat (3) do_eat();
        go_over(1'b0, 1'b0, 1'b0);

        // Session 4: 154 cycles in PLAY gives 10 ticks, frozen afterwards; start pulse during CONVERT ignored.
        do_start();
        check("ticks_cleared", time_ticks, 0);
        step(153);
        go_over(1'b0, 1'b0, 1'b1);
        check("ticks_10", time_ticks, 10);
        step(40);
        check("ticks_frozen", time_ticks, 10);
        check("done_idle", busy, 1'b0);

        // Session 5: saturation.
        do_start();
        check("ticks_restart", time_ticks, 0);
        eat = 1'b1;
        step(65534);
        eat = 1'b0;
        m_score = 65534;
        check("score_65534", score, 65534);
        do_eat();
        check("score_65535", score, 65535);
        do_eat();
        check("score_sat", score, 65535);
        go_over(1'b1, 1'b0, 1'b0);

        // eat/game_over in DONE change nothing.
        eat = 1'b1;
        step();
        eat = 1'b0;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        step(2);
        check("done_score", score, 65535);
        check("done_high", high_score, 65535);
        check("done_bcd", bcd_out, 20'h65535);
        check("done_valid", bcd_valid, 1'b1);
        check("done_rec", new_record, 1'b1);
        check("done_busy", busy, 1'b0);

        // start together with game_over in PLAY: conversion wins, score kept.
        do_start();
        do_eat();
        go_over(1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of CONVERT.
        do_start();
        do_eat();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        step(5);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        step();
        rst = 1'b0;
        m_high = 0;
        m_score = 0;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        eat = 1'b1;
        step();
        eat = 1'b0;
        step(20);
        check_zero("idle_ignore");

        // Recovery after reset: new record from a cleared high score.
        do_start();
        do_eat();
        go_over(1'b0, 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
